shift_deserializer: RTL and testbench

Serial-in, parallel-out receiver that pairs with the team's parallel-load right-shift transmitter. That transmitter emits its word LSB-first on `carry_out`, one bit per `shift_en` cycle. This block reassembles those bits into a `SIZE`-bit word, counts frame bits, and presents the word through a valid/ready handshake to downstream datapath logic. With the optional feature enabled, it also checks a trailing even-parity bit.

---
 rtl/shift_deserializer_pkg.sv | 36 +++
 rtl/shift_deserializer_bit_counter.sv | 48 ++++
 rtl/shift_deserializer.sv | 162 ++++++++++++++++
 tb/tb_shift_deserializer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// shift_deserializer_pkg
//
// Shared definitions for the serial-in / parallel-out receiver.
//
//   ST_COLLECT, ST_HOLD : receiver state encoding (1-bit, legacy compatible)
//   PARITY_EN           : 1 when the trailing even-parity bit is part of a
//                         frame (build macro SHIFT_DESER_PARITY_EN), else 0
//   frame_len()         : bits per frame for a given word width
//   count_width()       : bit-counter width able to hold frame_len()-1
// ---------------------------------------------------------------------------
package shift_deserializer_pkg;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

`ifdef SHIFT_DESER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Data bits plus the optional parity bit.
    function automatic int frame_len(input int size, input bit parity_en);
        return size + (parity_en ? 1 : 0);
    endfunction

    // The counter only has to reach FL-1, so clog2(FL) bits suffice; keep
    // at least one bit so the vector is never zero-width.
    function automatic int count_width(input int size, input bit parity_en);
        int fl;
        fl = frame_len(size, parity_en);
        return (fl <= 2) ? 1 : $clog2(fl);
    endfunction

endpackage

// File: rtl/shift_deserializer_bit_counter.sv
// ---------------------------------------------------------------------------
// deser_bit_counter
//
// Modulo-FL frame bit counter for shift_deserializer.
//
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset, count returns to 0
//   en   in   count one bit this cycle (wraps FL-1 -> 0)
//   clr  in   synchronous clear to 0, wins over en
//   tc   out  terminal count: the counter currently holds FL-1, so the bit
//             taken while tc is high is the last bit of the frame
// ---------------------------------------------------------------------------
module deser_bit_counter #(
    parameter int FL = 8,
    parameter int CW = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(FL - 1);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/shift_deserializer.sv
// ---------------------------------------------------------------------------
// shift_deserializer
//
// Reassembles an LSB-first serial stream (one bit per shift_en cycle) into a
// SIZE-bit word and offers it downstream with a valid/ready handshake.
//
// Build option: define SHIFT_DESER_PARITY_EN to append a trailing even-parity
// bit to every frame; the result is reported on parity_err.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   serial_in   in   serial data bit, sampled when shift_en=1
//   shift_en    in   bit strobe, one bit consumed per high cycle
//   clear       in   synchronous frame abort (highest priority)
//   data_ready  in   downstream accepts data_out
//   data_out    out  assembled word, bit 0 = first received bit
//   data_valid  out  data_out holds a complete frame (HOLD state)
//   overrun     out  one-cycle pulse after a bit was dropped in HOLD
//   parity_err  out  parity result of the held frame (parity builds only)
// ---------------------------------------------------------------------------
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    input  logic            shift_en,
    input  logic            clear,
    input  logic            data_ready,
    output logic [SIZE-1:0] data_out,
    output logic            data_valid,
    output logic            overrun
`ifdef SHIFT_DESER_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int FL = frame_len(SIZE, PARITY_EN);
    localparam int CW = count_width(SIZE, PARITY_EN);

    logic [0:0]      state_d;
    logic [0:0]      state_q;
    logic [SIZE-1:0] data_d;
    logic [SIZE-1:0] data_q;
    logic            overrun_d;
    logic            overrun_q;

    logic            hold;
    logic            xfer;
    logic            take_bit;
    logic            last_bit;
    logic            shift_data;
    logic            tc;

    // ------------------------------------------------------------------
    // Handshake and bit acceptance
    // ------------------------------------------------------------------
    always_comb begin
        hold     = (state_q == ST_HOLD);
        xfer     = hold && data_ready;
        // A bit is taken in COLLECT, or in HOLD when the held word leaves on
        // the same edge (the bit then opens the next frame, no bubble).
        // Clear aborts everything, including this bit.
        take_bit = shift_en && (!hold || data_ready) && !clear;
        // The counter sits at 0 in HOLD, so tc can only fire while collecting.
        last_bit = take_bit && tc;
    end

    deser_bit_counter #(
        .FL (FL),
        .CW (CW)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .en  (take_bit),
        .clr (clear),
        .tc  (tc)
    );

`ifdef SHIFT_DESER_PARITY_EN
    // The last frame bit is the parity bit; it never enters the word.
    assign shift_data = take_bit && !tc;
`else
    assign shift_data = take_bit;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_COLLECT;
        end else if (last_bit) begin
            state_d = ST_HOLD;
        end else if (xfer) begin
            state_d = ST_COLLECT;
        end
    end

    always_comb begin
        data_d = data_q;
        if (shift_data) begin
            data_d = {serial_in, data_q[SIZE-1:1]};
        end
    end

    // Drop-while-holding indication; an aborted frame is not an overrun.
    always_comb begin
        overrun_d = !clear && hold && shift_en && !data_ready;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_COLLECT;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    logic parity_err_d;
    logic parity_err_q;

    // When the parity bit arrives, data_q already holds all SIZE data bits
    // of the frame, so the even-parity check is a single reduction.
    always_comb begin
        parity_err_d = parity_err_q;
        if (clear) begin
            parity_err_d = 1'b0;
        end else if (last_bit) begin
            parity_err_d = (^data_q) ^ serial_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign data_out   = data_q;
    assign data_valid = (state_q == ST_HOLD);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
`timescale 1ns/1ps
module tb_shift_deserializer;

    localparam int SIZE = 8;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int FL = SIZE + 1;
`else
    localparam int FL = SIZE;
`endif

    logic            clk        = 1'b0;
    logic            rst        = 1'b0;
    logic            serial_in  = 1'b0;
    logic            shift_en   = 1'b0;
    logic            clear      = 1'b0;
    logic            data_ready = 1'b0;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            overrun;
`ifdef SHIFT_DESER_PARITY_EN
    logic            parity_err;
`endif

    shift_deserializer #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .shift_en   (shift_en),
        .clear      (clear),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
`ifdef SHIFT_DESER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model: a list of bits received so far and the
    // word currently offered downstream.
    bit              m_bits[$];
    bit              m_held;
    logic [SIZE-1:0] m_word;
    bit              m_ovr;
    bit              m_perr;

    function automatic void model_reset();
        m_bits.delete();
        m_held = 1'b0;
        m_word = '0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
    endfunction

    function automatic void model_step(bit se, bit sin, bit rdy, bit clr);
        logic [SIZE-1:0] w;
        bit p;
        m_ovr = 1'b0;
        if (clr) begin
            m_bits.delete();
            m_held = 1'b0;
            m_perr = 1'b0;
            return;
        end
        if (m_held && rdy) begin
            m_held = 1'b0;
        end else if (m_held && se) begin
            m_ovr = 1'b1;
            return;
        end
        if (se && !m_held) begin
            m_bits.push_back(sin);
            if (m_bits.size() == FL) begin
                w = '0;
                p = 1'b0;
                for (int i = 0; i < FL; i++) begin
                    p ^= m_bits[i];
                    if (i < SIZE) w[i] = m_bits[i];
                end
                m_word = w;
                m_perr = p;
                m_held = 1'b1;
                m_bits.delete();
            end
        end
    endfunction

    // One clock with the given inputs; returns #1 after the rising edge.
    task automatic cyc(input bit se, input bit sin, input bit rdy, input bit clr);
        shift_en   = se;
        serial_in  = sin;
        data_ready = rdy;
        clear      = clr;
        model_step(se, sin, rdy, clr);
        @(posedge clk);
        #1;
        shift_en   = 1'b0;
        data_ready = 1'b0;
        clear      = 1'b0;
    endtask

    // Sends a full frame LSB first; bad_par inverts the even-parity bit.
    task automatic send_word(input logic [SIZE-1:0] w, input bit rdy, input bit bad_par);
        for (int i = 0; i < SIZE; i++) cyc(1'b1, w[i], rdy, 1'b0);
        if (FL > SIZE) cyc(1'b1, (^w) ^ bad_par, rdy, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++;
        if (data_out !== '0) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
`ifdef SHIFT_DESER_PARITY_EN
        checks++;
        if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity got=%b exp=0", parity_err); end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [SIZE-1:0] w;
        w = 8'hA5;
        for (int i = 0; i < FL; i++) begin
            cyc(1'b1, (i < SIZE) ? w[i] : 1'b0, 1'b0, 1'b0);
            checks++;
            if (data_valid !== (i == FL - 1)) begin
                failures++;
                $display("FAIL basic_valid bit=%0d got=%b exp=%b", i, data_valid, (i == FL - 1));
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
                failures++;
                $display("FAIL basic_hold cyc=%0d got=%h/%b exp=a5/1", k, data_out, data_valid);
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", data_valid); end
    endtask

    task automatic test_back_to_back();
        bit              seq[$];
        logic [SIZE-1:0] words[2];
        int              vcount;
        words[0] = 8'h3C;
        words[1] = 8'hFF;
        vcount   = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < SIZE; i++) seq.push_back(words[f][i]);
            if (FL > SIZE) seq.push_back(^words[f]);
        end
        for (int c = 0; c < seq.size() + 3; c++) begin
            if (c < seq.size()) cyc(1'b1, seq[c], 1'b1, 1'b0);
            else                cyc(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (data_valid !== m_held) begin
                failures++;
                $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", c, data_valid, m_held);
            end
            if (data_valid === 1'b1) begin
                checks++;
                if (vcount > 1 || data_out !== words[vcount]) begin
                    failures++;
                    $display("FAIL b2b_word idx=%0d got=%h exp=%h", vcount, data_out, words[vcount % 2]);
                end
                vcount++;
            end
        end
        checks++;
        if (vcount !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", vcount); end
    endtask

    task automatic test_overrun();
        int pulses;
        pulses = 0;
        send_word(8'h12, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc((c % 2) == 0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (overrun !== ((c % 2) == 0)) begin
                failures++;
                $display("FAIL overrun_pulse cyc=%0d got=%b exp=%b", c, overrun, ((c % 2) == 0));
            end
            if (overrun === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 2) begin failures++; $display("FAIL overrun_count got=%0d exp=2", pulses); end
        checks++;
        if (data_out !== 8'h12 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_data got=%h/%b exp=12/1", data_out, data_valid);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        logic [SIZE-1:0] w;
        w = 8'h81;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL clear_valid got=%b exp=0", data_valid); end
        for (int i = 0; i < FL; i++) begin
            cyc(1'b1, (i < SIZE) ? w[i] : ^w, 1'b0, 1'b0);
            checks++;
            if (data_valid !== (i == FL - 1)) begin
                failures++;
                $display("FAIL clear_frame bit=%0d got=%b exp=%b", i, data_valid, (i == FL - 1));
            end
        end
        checks++;
        if (data_out !== 8'h81) begin failures++; $display("FAIL clear_word got=%h exp=81", data_out); end
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (data_valid !== 1'b0) begin failures++; $display("FAIL clear_hold got=%b exp=0", data_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (data_out !== '0 || data_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL areset_mid got=%h/%b/%b exp=00/0/0", data_out, data_valid, overrun);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        send_word(8'hC3, 1'b0, 1'b1);
        checks++;
        if (data_out !== 8'hC3 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got=%h/%b exp=c3/1", data_out, data_valid);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (data_out !== '0 || data_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL areset_hold got=%h/%b/%b exp=00/0/0", data_out, data_valid, overrun);
        end
`ifdef SHIFT_DESER_PARITY_EN
        checks++;
        if (parity_err !== 1'b0) begin failures++; $display("FAIL areset_parity got=%b exp=0", parity_err); end
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0);
        checks++;
        if (data_out !== 8'h5A || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_after got=%h/%b exp=5a/1", data_out, data_valid);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef SHIFT_DESER_PARITY_EN
    task automatic test_parity();
        send_word(8'hA5, 1'b0, 1'b0);
        checks++;
        if (parity_err !== 1'b0 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL parity_good got=%b/%b exp=0/1", parity_err, data_valid);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1);
        checks++;
        if (parity_err !== 1'b1 || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL parity_bad got=%b/%h exp=1/a5", parity_err, data_out);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_clear got=%b exp=0", parity_err); end
    endtask
`endif

    task automatic test_random();
        int prints;
        prints = 0;
        for (int c = 0; c < 600; c++) begin
            cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0, ($urandom % 60) == 0);
            checks++;
            if (data_valid !== m_held || overrun !== m_ovr ||
                (m_held && data_out !== m_word)
`ifdef SHIFT_DESER_PARITY_EN
                || parity_err !== m_perr
`endif
               ) begin
                failures++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random cyc=%0d got=%b/%b/%h exp=%b/%b/%h",
                             c, data_valid, overrun, data_out, m_held, m_ovr, m_word);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_clear();
        test_async_reset();
`ifdef SHIFT_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
